// File: rtl/aes32_xif_queue.sv
// aes32_xif_queue: accepts the scalar AES round instructions (aes32esi, aes32esmi,
// aes32dsi, aes32dsmi) over an issue/commit/result interface. It holds them in an
// in-order queue until they are committed, drops killed ones, and returns the
// computed rd value through a single registered result slot.
//
// Ports:
//   clk_i, rst_ni          clock; synchronous active-low reset
//   issue_*                issue handshake: instruction word, ID and operands (rs1 in
//                          [31:0], rs2 in [63:32]); accept/writeback flags are
//                          combinational
//   commit_*               commit strobe for one ID, optionally killing it
//   result_*               registered result (valid/ready) with ID, rd index, data, we
//   occupancy_o            number of valid queue entries (0..DEPTH)
module aes32_xif_queue #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ENABLE_DEC = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [31:0]             issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]   issue_id_i,
    input  logic [63:0]             issue_rs_i,
    input  logic [1:0]              issue_rs_valid_i,
    output logic                    issue_accept_o,
    output logic                    issue_writeback_o,
    input  logic                    commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]   commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic [X_ID_WIDTH-1:0]   result_id_o,
    output logic [31:0]             result_data_o,
    output logic [4:0]              result_rd_o,
    output logic                    result_we_o,
    output logic [$clog2(DEPTH):0]  occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH) + 1;
    localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

    typedef enum logic [1:0] {OpEsi, OpEsmi, OpDsi, OpDsmi} aes_op_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        aes_op_e               op;
        logic [1:0]            bs;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
        logic                  committed;
        logic                  killed;
    } entry_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers; S-boxes are derived from the field inverse and the
    // affine transform instead of lookup tables.
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for nonzero a, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] a, input int unsigned n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rol8(i, 1) ^ rol8(i, 2) ^ rol8(i, 3) ^ rol8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] t;
        t = rol8(a, 1) ^ rol8(a, 3) ^ rol8(a, 6) ^ 8'h05;
        return gf_inv(t);
    endfunction

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    logic    dec_is_aes;
    logic    dec_known;
    aes_op_e dec_op;

    always_comb begin
        dec_is_aes = (issue_instr_i[6:0] == 7'b0110011) && (issue_instr_i[14:12] == 3'b000);
        dec_known  = 1'b0;
        dec_op     = OpEsi;
        case (issue_instr_i[29:25])
            5'b10001: begin dec_op = OpEsi;  dec_known = 1'b1; end
            5'b10011: begin dec_op = OpEsmi; dec_known = 1'b1; end
            5'b10101: begin dec_op = OpDsi;  dec_known = (ENABLE_DEC != 0); end
            5'b10111: begin dec_op = OpDsmi; dec_known = (ENABLE_DEC != 0); end
            default:  begin dec_op = OpEsi;  dec_known = 1'b0; end
        endcase
    end

    // Register-source fields are not needed; the operand values arrive on issue_rs_i.
    logic unused_instr_bits;
    assign unused_instr_bits = ^issue_instr_i[24:15];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      vld_q, vld_d;
    entry_t                ent_q [DEPTH];
    entry_t                ent_d [DEPTH];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [OccW-1:0]       occ_q, occ_d;
    logic                  res_valid_q, res_valid_d;
    logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [31:0]           res_data_q, res_data_d;
    logic [4:0]            res_rd_q, res_rd_d;

    assign issue_accept_o    = dec_is_aes & dec_known;
    assign issue_writeback_o = dec_is_aes & dec_known;
    assign issue_ready_o     = rst_ni & issue_rs_valid_i[0] & issue_rs_valid_i[1] &
                               (occ_q != DepthOcc);

    assign occupancy_o    = occ_q;
    assign result_valid_o = res_valid_q;
    assign result_we_o    = res_valid_q;
    assign result_id_o    = res_id_q;
    assign result_data_o  = res_data_q;
    assign result_rd_o    = res_rd_q;

    // ------------------------------------------------------------------
    // Datapath: result of the head entry
    // ------------------------------------------------------------------
    entry_t      head_ent;
    logic [7:0]  sel_byte;
    logic [7:0]  so_fwd;
    logic [7:0]  so_inv;
    logic [31:0] mixed;
    logic [63:0] rot_dbl;
    logic [31:0] head_result;

    always_comb begin
        head_ent = ent_q[head_q];
        sel_byte = head_ent.rs2[{head_ent.bs, 3'b000} +: 8];
        so_fwd   = sbox_fwd(sel_byte);
        so_inv   = sbox_inv(sel_byte);
        mixed    = 32'h0;
        unique case (head_ent.op)
            OpEsi:   mixed = {24'h0, so_fwd};
            OpEsmi:  mixed = {xtime(so_fwd) ^ so_fwd, so_fwd, so_fwd, xtime(so_fwd)};
            OpDsi:   mixed = {24'h0, so_inv};
            OpDsmi:  mixed = {gf_mul(so_inv, 8'h0b), gf_mul(so_inv, 8'h0d),
                              gf_mul(so_inv, 8'h09), gf_mul(so_inv, 8'h0e)};
            default: mixed = 32'h0;
        endcase
        // Rotate left by bs*8: take the upper half of the doubled word after the shift.
        rot_dbl     = {mixed, mixed} << {head_ent.bs, 3'b000};
        head_result = head_ent.rs1 ^ rot_dbl[63:32];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic            push;
    logic            head_vld;
    logic            drop;
    logic            emit;
    logic            pop;
    logic            found;
    logic [PtrW-1:0] scan_idx;

    always_comb begin
        vld_d       = vld_q;
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        found       = 1'b0;
        scan_idx    = '0;

        push     = issue_valid_i & issue_ready_o & issue_accept_o;
        head_vld = vld_q[head_q];
        drop     = head_vld & head_ent.committed & head_ent.killed;
        emit     = head_vld & head_ent.committed & ~head_ent.killed &
                   (~res_valid_q | result_ready_i);
        pop      = drop | emit;

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PtrW'(1);
        end

        // Push cannot collide with the popped slot: tail==head only when empty or full.
        if (push) begin
            vld_d[tail_q] = 1'b1;
            ent_d[tail_q] = '{id: issue_id_i, rd: issue_instr_i[11:7], op: dec_op,
                              bs: issue_instr_i[31:30], rs1: issue_rs_i[31:0],
                              rs2: issue_rs_i[63:32], committed: 1'b0, killed: 1'b0};
            tail_d        = tail_q + PtrW'(1);
        end

        // Commit goes to the oldest matching uncommitted entry; the entry being
        // pushed this cycle is the youngest, so it is tried last.
        if (commit_valid_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                scan_idx = head_q + PtrW'(k);
                if (!found && vld_q[scan_idx] && !ent_q[scan_idx].committed &&
                    (ent_q[scan_idx].id == commit_id_i)) begin
                    found                     = 1'b1;
                    ent_d[scan_idx].committed = 1'b1;
                    ent_d[scan_idx].killed    = commit_kill_i;
                end
            end
            if (!found && push && (issue_id_i == commit_id_i)) begin
                ent_d[tail_q].committed = 1'b1;
                ent_d[tail_q].killed    = commit_kill_i;
            end
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase

        if (emit) begin
            res_valid_d = 1'b1;
            res_id_d    = head_ent.id;
            res_data_d  = head_result;
            res_rd_d    = head_ent.rd;
        end else if (result_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
        end else begin
            vld_q       <= vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
        end
    end

    // Entry payload needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_aes32_xif_queue.sv
// Directed bench for aes32_xif_queue: one instance with decryption enabled, one
// with it disabled. Expected values are hand-computed AES S-box / MixColumn results.
module tb_aes32_xif_queue;

    localparam int unsigned IdW = 4;

    localparam logic [4:0] F5Esi  = 5'b10001;
    localparam logic [4:0] F5Esmi = 5'b10011;
    localparam logic [4:0] F5Dsi  = 5'b10101;
    localparam logic [4:0] F5Dsmi = 5'b10111;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           issue_valid;
    logic           issue_valid1;
    logic           issue_ready;
    logic           issue_ready1;
    logic [31:0]    issue_instr;
    logic [IdW-1:0] issue_id;
    logic [63:0]    issue_rs;
    logic [1:0]     issue_rs_valid;
    logic           issue_accept;
    logic           issue_accept1;
    logic           issue_wb;
    logic           issue_wb1;
    logic           commit_valid;
    logic [IdW-1:0] commit_id;
    logic           commit_kill;
    logic           result_valid;
    logic           result_valid1;
    logic           result_ready;
    logic [IdW-1:0] result_id;
    logic [IdW-1:0] result_id1;
    logic [31:0]    result_data;
    logic [31:0]    result_data1;
    logic [4:0]     result_rd;
    logic [4:0]     result_rd1;
    logic           result_we;
    logic           result_we1;
    logic [2:0]     occupancy;
    logic [2:0]     occupancy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes32_xif_queue #(.X_ID_WIDTH(IdW), .DEPTH(4), .ENABLE_DEC(1)) u_dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs_i        (issue_rs),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_wb),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id),
        .result_data_o     (result_data),
        .result_rd_o       (result_rd),
        .result_we_o       (result_we),
        .occupancy_o       (occupancy)
    );

    aes32_xif_queue #(.X_ID_WIDTH(IdW), .DEPTH(4), .ENABLE_DEC(0)) u_dut_nodec (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .issue_valid_i     (issue_valid1),
        .issue_ready_o     (issue_ready1),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs_i        (issue_rs),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept1),
        .issue_writeback_o (issue_wb1),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid1),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id1),
        .result_data_o     (result_data1),
        .result_rd_o       (result_rd1),
        .result_we_o       (result_we1),
        .occupancy_o       (occupancy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] f5, input logic [1:0] bs,
                                             input logic [4:0] rd);
        return {bs, f5, 10'b0, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic do_issue(input logic [31:0] instr, input logic [IdW-1:0] id,
                            input logic [31:0] rs1, input logic [31:0] rs2);
        issue_instr = instr;
        issue_id    = id;
        issue_rs    = {rs2, rs1};
        issue_valid = 1'b1;
        #1;
        for (int n = 0; n < 50 && !issue_ready; n++) step();
        check_eq("issue_ready_at_issue", issue_ready, 1'b1);
        step();
        issue_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [IdW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        step();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [IdW-1:0] exp_id,
                               input logic [4:0] exp_rd, input logic [31:0] exp_data);
        for (int n = 0; n < 50 && !result_valid; n++) step();
        check_eq({tag, "_valid"}, result_valid, 1'b1);
        check_eq({tag, "_id"}, result_id, exp_id);
        check_eq({tag, "_rd"}, result_rd, exp_rd);
        check_eq({tag, "_data"}, result_data, exp_data);
        check_eq({tag, "_we"}, result_we, 1'b1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] instr, input logic [IdW-1:0] id,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] exp_data);
        do_issue(instr, id, rs1, rs2);
        do_commit(id, 1'b0);
        wait_result(tag, id, instr[11:7], exp_data);
    endtask

    initial begin
        int seen;
        rst_n          = 1'b0;
        issue_valid    = 1'b0;
        issue_valid1   = 1'b0;
        issue_instr    = 32'h0;
        issue_id       = '0;
        issue_rs       = 64'h0;
        issue_rs_valid = 2'b11;
        commit_valid   = 1'b0;
        commit_id      = '0;
        commit_kill    = 1'b0;
        result_ready   = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_issue_ready", issue_ready, 1'b0);
        check_eq("rst_result_valid", result_valid, 1'b0);
        check_eq("rst_result_we", result_we, 1'b0);
        check_eq("rst_result_id", result_id, 4'd0);
        check_eq("rst_result_data", result_data, 32'h0);
        check_eq("rst_result_rd", result_rd, 5'd0);
        check_eq("rst_occupancy", occupancy, 3'd0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_issue_ready", issue_ready, 1'b1);

        // Operand-valid gating of ready
        issue_rs_valid = 2'b01;
        #1;
        check_eq("ready_needs_rs2", issue_ready, 1'b0);
        issue_rs_valid = 2'b11;

        // aes32esi basic flow with exact latency and hold
        issue_instr = 32'h22B502B3;
        #1;
        check_eq("esi_accept", issue_accept, 1'b1);
        check_eq("esi_writeback", issue_wb, 1'b1);
        do_issue(32'h22B502B3, 4'd3, 32'h0, 32'h0);
        check_eq("esi_occ", occupancy, 3'd1);
        do_commit(4'd3, 1'b0);
        check_eq("esi_not_yet", result_valid, 1'b0);
        step();
        check_eq("esi_valid", result_valid, 1'b1);
        check_eq("esi_id", result_id, 4'd3);
        check_eq("esi_rd", result_rd, 5'd5);
        check_eq("esi_data", result_data, 32'h00000063);
        check_eq("esi_we", result_we, 1'b1);
        step();
        check_eq("esi_hold_valid", result_valid, 1'b1);
        check_eq("esi_hold_data", result_data, 32'h00000063);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_eq("esi_consumed", result_valid, 1'b0);
        check_eq("esi_we_low", result_we, 1'b0);
        check_eq("esi_occ_empty", occupancy, 3'd0);

        // Non-AES instruction: handshake completes, nothing allocated
        issue_instr = 32'h00B50533;
        #1;
        check_eq("add_accept", issue_accept, 1'b0);
        check_eq("add_writeback", issue_wb, 1'b0);
        do_issue(32'h00B50533, 4'd6, 32'h1, 32'h2);
        check_eq("add_occ", occupancy, 3'd0);

        // Operation results
        run_one("esmi0", mk_instr(F5Esmi, 2'd0, 5'd7), 4'd4, 32'h0, 32'h0, 32'hA56363C6);
        run_one("dsi0", mk_instr(F5Dsi, 2'd0, 5'd8), 4'd5, 32'h0, 32'h0, 32'h00000052);
        run_one("dsmi0", mk_instr(F5Dsmi, 2'd0, 5'd9), 4'd6, 32'h0, 32'h0, 32'h50A7F451);
        run_one("esmi_bs3", mk_instr(F5Esmi, 2'd3, 5'd10), 4'd7, 32'h0, 32'h0, 32'hC6A56363);
        run_one("esi_bs1", mk_instr(F5Esi, 2'd1, 5'd11), 4'd8, 32'h12345678, 32'h00000100,
                32'h12342A78);

        // Out-of-order commits, in-order results
        do_issue(mk_instr(F5Esi, 2'd0, 5'd1), 4'd1, 32'h0, 32'h0);
        do_issue(mk_instr(F5Esi, 2'd0, 5'd2), 4'd2, 32'h0, 32'h0);
        do_issue(mk_instr(F5Esi, 2'd0, 5'd3), 4'd3, 32'h0, 32'h0);
        check_eq("order_occ", occupancy, 3'd3);
        do_commit(4'd3, 1'b0);
        step();
        check_eq("order_blocked", result_valid, 1'b0);
        do_commit(4'd1, 1'b0);
        do_commit(4'd2, 1'b0);
        wait_result("order_r1", 4'd1, 5'd1, 32'h63);
        wait_result("order_r2", 4'd2, 5'd2, 32'h63);
        wait_result("order_r3", 4'd3, 5'd3, 32'h63);

        // Kill drops the head silently
        do_issue(mk_instr(F5Esi, 2'd0, 5'd1), 4'd1, 32'h0, 32'h0);
        do_issue(mk_instr(F5Esi, 2'd0, 5'd2), 4'd2, 32'h0, 32'h0);
        do_commit(4'd1, 1'b1);
        do_commit(4'd2, 1'b0);
        wait_result("kill_r2", 4'd2, 5'd2, 32'h63);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (result_valid) seen++;
            step();
        end
        check_eq("kill_no_extra", seen, 0);
        check_eq("kill_occ", occupancy, 3'd0);

        // Fill to DEPTH with backpressure, then drain across pointer wrap
        for (int i = 0; i < 4; i++) begin
            do_issue(mk_instr(F5Esi, 2'd0, 5'(4 + i)), 4'(4 + i), 32'h0, 32'h0);
        end
        check_eq("full_ready", issue_ready, 1'b0);
        check_eq("full_occ", occupancy, 3'd4);
        for (int i = 0; i < 4; i++) do_commit(4'(4 + i), 1'b0);
        result_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid) begin
                check_eq("drain_id", result_id, 4'(4 + seen));
                seen++;
            end
            step();
        end
        result_ready = 1'b0;
        check_eq("drain_count", seen, 4);
        check_eq("drain_occ", occupancy, 3'd0);
        check_eq("drain_ready", issue_ready, 1'b1);

        // Decryption disabled instance
        issue_instr = mk_instr(F5Dsi, 2'd0, 5'd3);
        #1;
        check_eq("nodec_dsi_accept", issue_accept1, 1'b0);
        check_eq("nodec_dsi_wb", issue_wb1, 1'b0);
        check_eq("dec_dsi_accept", issue_accept, 1'b1);
        issue_valid1 = 1'b1;
        step();
        issue_valid1 = 1'b0;
        check_eq("nodec_occ", occupancy1, 3'd0);
        issue_instr = mk_instr(F5Dsmi, 2'd0, 5'd3);
        #1;
        check_eq("nodec_dsmi_accept", issue_accept1, 1'b0);
        issue_instr = mk_instr(F5Esi, 2'd0, 5'd3);
        #1;
        check_eq("nodec_esi_accept", issue_accept1, 1'b1);

        // Reset mid-operation discards pending work
        do_issue(mk_instr(F5Esi, 2'd0, 5'd8), 4'd8, 32'h0, 32'h0);
        do_issue(mk_instr(F5Esi, 2'd0, 5'd9), 4'd9, 32'h0, 32'h0);
        check_eq("midrst_occ_before", occupancy, 3'd2);
        do_commit(4'd8, 1'b0);
        rst_n = 1'b0;
        step();
        check_eq("midrst_occ", occupancy, 3'd0);
        check_eq("midrst_valid", result_valid, 1'b0);
        check_eq("midrst_ready", issue_ready, 1'b0);
        rst_n = 1'b1;
        do_commit(4'd9, 1'b0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (result_valid) seen++;
            step();
        end
        check_eq("midrst_no_stale", seen, 0);
        check_eq("midrst_occ_after", occupancy, 3'd0);
        run_one("post_rst_esi", mk_instr(F5Esi, 2'd0, 5'd12), 4'd10, 32'h0, 32'h0, 32'h63);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
